// File: rtl/bus_dma_ctrl.sv
// Memory-to-memory byte copier that borrows the CPU bus via nBUSRQ/nBUSAK,
// moving up to BURST bytes per bus tenure with fixed-length read/write strobes.
module bus_dma_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned BURST         = 16
) (
  input  logic        i_clk,
  input  logic        i_nclr,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_src,
  input  logic [15:0] i_dst,
  input  logic [15:0] i_len,
  input  logic        i_nbusak,
  input  logic [7:0]  i_dma_din,
  output logic        o_nbusrq,
  output logic [15:0] o_dma_addr,
  output logic [7:0]  o_dma_dout,
  output logic        o_dma_nmreq,
  output logic        o_dma_nrd,
  output logic        o_dma_nwr,
  output logic        o_dma_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_remain
);

  localparam logic [3:0]  LastStb  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0]  GapCnt   = 4'(ACCESS_CYCLES);
  localparam logic [15:0] BurstLim = 16'(BURST);
  localparam bit          BurstOn  = (BURST != 0);

  typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StYield, StRel} state_e;

  state_e      r_state, w_state;
  logic [15:0] r_src, w_src;
  logic [15:0] r_dst, w_dst;
  logic [15:0] r_remain, w_remain;
  logic [15:0] r_burst, w_burst;
  logic [3:0]  r_cnt, w_cnt;
  logic [7:0]  r_data, w_data;
  logic        r_abort, w_abort;
  logic        r_done, w_done;
  logic        w_abort_seen;

  assign w_abort_seen = r_abort | i_abort;

  always_ff @(posedge i_clk) begin
    if (!i_nclr) begin
      r_state  <= StIdle;
      r_src    <= '0;
      r_dst    <= '0;
      r_remain <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_abort  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_src    <= w_src;
      r_dst    <= w_dst;
      r_remain <= w_remain;
      r_burst  <= w_burst;
      r_cnt    <= w_cnt;
      r_data   <= w_data;
      r_abort  <= w_abort;
      r_done   <= w_done;
    end
  end

  // Each RD and WR phase is ACCESS_CYCLES strobe cycles plus one trailing
  // all-high cycle, which provides the mandatory gap between accesses.
  always_comb begin
    w_state  = r_state;
    w_src    = r_src;
    w_dst    = r_dst;
    w_remain = r_remain;
    w_burst  = r_burst;
    w_cnt    = r_cnt;
    w_data   = r_data;
    w_abort  = r_abort | ((r_state != StIdle) & i_abort);
    w_done   = 1'b0;
    case (r_state)
      StIdle: begin
        w_abort = 1'b0;
        w_cnt   = '0;
        w_burst = '0;
        if (i_start) begin
          w_src    = i_src;
          w_dst    = i_dst;
          w_remain = i_len;
          if (i_len == 16'd0) begin
            w_done = 1'b1;
          end else begin
            w_state = StReq;
          end
        end
      end
      StReq: begin
        if (w_abort_seen) begin
          w_state = StRel;
        end else if (!i_nbusak) begin
          w_state = StRd;
          w_cnt   = '0;
        end
      end
      StRd: begin
        if (r_cnt == LastStb) begin
          w_data = i_dma_din;
        end
        if (r_cnt == GapCnt) begin
          w_cnt   = '0;
          w_state = StWr;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      StWr: begin
        if (r_cnt == GapCnt) begin
          w_cnt    = '0;
          w_src    = r_src + 16'd1;
          w_dst    = r_dst + 16'd1;
          w_remain = r_remain - 16'd1;
          w_burst  = r_burst + 16'd1;
          if ((r_remain == 16'd1) || w_abort_seen) begin
            w_state = StRel;
          end else if (BurstOn && (w_burst == BurstLim)) begin
            w_state = StYield;
          end else begin
            w_state = StRd;
          end
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      StYield: begin
        if (i_nbusak) begin
          w_burst = '0;
          w_state = StReq;
        end
      end
      StRel: begin
        if (i_nbusak) begin
          w_done  = 1'b1;
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_comb begin
    o_dma_oe    = (r_state == StRd) || (r_state == StWr);
    o_dma_nrd   = !((r_state == StRd) && (r_cnt != GapCnt));
    o_dma_nwr   = !((r_state == StWr) && (r_cnt != GapCnt));
    o_dma_nmreq = o_dma_nrd & o_dma_nwr;
    o_nbusrq    = !((r_state == StReq) || o_dma_oe);
    o_dma_addr  = (r_state == StRd) ? r_src : (r_state == StWr) ? r_dst : 16'd0;
    o_dma_dout  = r_data;
    o_busy      = (r_state != StIdle);
    o_done      = r_done;
    o_remain    = r_remain;
  end

endmodule

// File: tb/tb_bus_dma_ctrl.sv
// Randomized bench for bus_dma_ctrl: a byte-copy reference model predicts reads,
// writes, tenures and REMAIN; a negedge monitor checks bus protocol every cycle.
module tb_bus_dma_ctrl;
  localparam int unsigned TbAc    = 3;
  localparam int unsigned TbBurst = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nclr, start, abort, nbusak;
  logic [15:0] src, dst, len;
  logic [7:0]  din;
  logic        nbusrq, nmreq, nrd, nwr, oe, busy, done;
  logic [15:0] addr, remain;
  logic [7:0]  dout;

  bus_dma_ctrl #(.ACCESS_CYCLES(TbAc), .BURST(TbBurst)) dut (
    .i_clk(clk), .i_nclr(nclr), .i_start(start), .i_abort(abort),
    .i_src(src), .i_dst(dst), .i_len(len), .i_nbusak(nbusak), .i_dma_din(din),
    .o_nbusrq(nbusrq), .o_dma_addr(addr), .o_dma_dout(dout), .o_dma_nmreq(nmreq),
    .o_dma_nrd(nrd), .o_dma_nwr(nwr), .o_dma_oe(oe), .o_busy(busy), .o_done(done),
    .o_remain(remain)
  );

  logic [7:0] mem       [0:65535];
  logic [7:0] model_mem [0:65535];
  assign din = mem[addr];

  // CPU side: grant follows the request after gnt_d cycles; optional noise while mastering
  logic [3:0] pipe = 4'hF;
  int         gnt_d = 1;
  bit         glitch_en = 1'b0;
  logic       rnd_bit = 1'b1;
  always @(posedge clk) begin
    pipe    <= {pipe[2:0], nbusrq};
    rnd_bit <= 1'($urandom_range(0, 1));
  end
  assign nbusak = (glitch_en && oe) ? rnd_bit : pipe[gnt_d-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [15:0] rd_log[$], exp_rd[$];
  logic [23:0] wr_log[$], exp_wr[$];
  int          ten_log[$], exp_ten[$];
  int          done_cnt = 0;
  bit          mon_en = 1'b0;

  initial begin
    bit          prev_rd, prev_wr, prev_rq, prev_done;
    int          rd_run, wr_run, ten_cur;
    logic [15:0] rd_addr, wr_addr;
    logic [7:0]  wr_data;
    prev_rd = 1; prev_wr = 1; prev_rq = 1; prev_done = 0;
    rd_run = 0; wr_run = 0; ten_cur = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_rd = 1; prev_wr = 1; prev_rq = 1; prev_done = 0;
        rd_run = 0; wr_run = 0; ten_cur = 0;
      end else begin
        chk(nrd || nwr, "rd_wr_overlap", {nrd, nwr}, 2'b11);
        chk(oe || (nmreq && nrd && nwr), "strobe_without_oe", {nmreq, nrd, nwr}, 3'b111);
        chk(nmreq == (nrd & nwr), "mreq_pairing", nmreq, nrd & nwr);
        chk(!oe || !nbusrq, "oe_without_request", nbusrq, 0);
        chk(busy || nbusrq, "request_while_idle", nbusrq, 1);
        chk(!(!prev_rd && !nwr) && !(!prev_wr && !nrd), "no_idle_gap",
            {prev_rd, nwr, prev_wr, nrd}, 4'hF);
        if (!nrd) begin
          if (rd_run == 0) rd_addr = addr;
          else chk(addr == rd_addr, "rd_addr_stable", addr, rd_addr);
          rd_run++;
        end else if (rd_run != 0) begin
          chk(rd_run == TbAc, "rd_strobe_len", rd_run, TbAc);
          rd_log.push_back(rd_addr);
          rd_run = 0;
        end
        if (!nwr) begin
          if (wr_run == 0) begin
            wr_addr = addr;
            wr_data = dout;
          end else begin
            chk({addr, dout} == {wr_addr, wr_data}, "wr_bus_stable", {addr, dout},
                {wr_addr, wr_data});
          end
          wr_run++;
        end else if (wr_run != 0) begin
          chk(wr_run == TbAc, "wr_strobe_len", wr_run, TbAc);
          wr_log.push_back({wr_addr, wr_data});
          mem[wr_addr] = wr_data;
          ten_cur++;
          wr_run = 0;
        end
        if (prev_rq && !nbusrq) ten_cur = 0;
        if (!prev_rq && nbusrq) ten_log.push_back(ten_cur);
        if (done) begin
          done_cnt++;
          chk(!busy, "busy_at_done", busy, 0);
          chk(!prev_done, "done_one_cycle", prev_done, 0);
        end
        prev_rd = nrd; prev_wr = nwr; prev_rq = nbusrq; prev_done = done;
      end
    end
  end

  logic [15:0] last_rem;

  // mode 0: no abort, 1: abort while requesting, 2: abort during read of byte k
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int mode, input int k, input bit busy_start);
    int          n, rd_falls, budget, rem_bytes;
    bit          prev_nrd;
    logic [15:0] a, rem_snap;
    logic [7:0]  v;
    n = (mode == 0) ? int'(l) : (mode == 1) ? 0 : k;
    model_mem = mem;
    exp_rd.delete(); exp_wr.delete(); exp_ten.delete();
    for (int i = 0; i < n; i++) begin
      a = s + 16'(i);
      exp_rd.push_back(a);
      v = model_mem[a];
      model_mem[d + 16'(i)] = v;
      exp_wr.push_back({d + 16'(i), v});
    end
    if (n == 0) exp_ten.push_back(0);
    rem_bytes = n;
    while (rem_bytes > 0) begin
      exp_ten.push_back((rem_bytes > int'(TbBurst)) ? int'(TbBurst) : rem_bytes);
      rem_bytes -= int'(TbBurst);
    end
    rd_log.delete(); wr_log.delete(); ten_log.delete();
    done_cnt = 0;
    @(negedge clk); #1;
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
    if (mode == 1) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    rd_falls = 0; prev_nrd = 1'b1; rem_snap = '0;
    budget = 300 + int'(l) * 60;
    for (int cyc = 0; cyc < budget && done_cnt == 0; cyc++) begin
      @(negedge clk); #1;
      abort = 1'b0;
      if (start) begin
        start = 1'b0;
        chk(remain == rem_snap, "start_while_busy_remain", remain, rem_snap);
      end
      if (prev_nrd && !nrd) begin
        rd_falls++;
        if (mode == 2 && rd_falls == k) abort = 1'b1;
        if (busy_start && rd_falls == 1) begin
          rem_snap = remain;
          start = 1'b1;
          len = 16'($urandom_range(0, 3));
          src = 16'($urandom); dst = 16'($urandom);
        end
      end
      prev_nrd = nrd;
    end
    chk(done_cnt == 1, "done_seen", done_cnt, 1);
    last_rem = remain;
    chk(remain == l - 16'(n), "remain_at_done", remain, l - 16'(n));
    chk(!busy && nbusrq, "idle_after_done", {busy, nbusrq}, 2'b01);
    repeat (4) @(negedge clk);
    #1;
    chk(done_cnt == 1, "single_done", done_cnt, 1);
    chk(rd_log.size() == exp_rd.size(), "read_count", rd_log.size(), exp_rd.size());
    chk(wr_log.size() == exp_wr.size(), "write_count", wr_log.size(), exp_wr.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      chk(rd_log[i] == exp_rd[i], "read_addr", rd_log[i], exp_rd[i]);
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      chk(wr_log[i] == exp_wr[i], "write_addr_data", wr_log[i], exp_wr[i]);
    chk(ten_log.size() == exp_ten.size(), "tenure_count", ten_log.size(), exp_ten.size());
    for (int i = 0; i < ten_log.size() && i < exp_ten.size(); i++)
      chk(ten_log[i] == exp_ten[i], "tenure_writes", ten_log[i], exp_ten[i]);
  endtask

  task automatic zero_len();
    ten_log.delete();
    done_cnt = 0;
    @(negedge clk); #1;
    src = 16'($urandom); dst = 16'($urandom); len = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk(done == 1'b1, "zero_len_done_next_cycle", done, 1);
    chk(nbusrq == 1'b1, "zero_len_no_request", nbusrq, 1);
    chk(remain == 16'd0, "zero_len_remain", remain, 0);
    repeat (3) @(negedge clk);
    #1;
    chk(done_cnt == 1, "zero_len_single_done", done_cnt, 1);
    chk(ten_log.size() == 0, "zero_len_no_tenure", ten_log.size(), 0);
  endtask

  task automatic reset_mid_write();
    int guard;
    @(negedge clk); #1;
    src = 16'h2000; dst = 16'h3000; len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (nwr && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    chk(!nwr, "reset_test_reached_write", nwr, 0);
    mon_en = 1'b0;
    nclr = 1'b0;
    @(posedge clk); #1;
    chk(nbusrq && !oe, "reset_drops_request", {nbusrq, oe}, 2'b10);
    chk(nmreq && nrd && nwr, "reset_drops_strobes", {nmreq, nrd, nwr}, 3'b111);
    chk(!done && !busy, "reset_no_done", {done, busy}, 2'b00);
    chk(remain == 16'd0 && addr == 16'd0, "reset_regs", {remain, addr}, 32'd0);
    @(negedge clk); #1;
    nclr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(!done && !busy && nbusrq, "post_reset_idle", {done, busy, nbusrq}, 3'b001);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    int l, mode, k;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    nclr = 1'b0; start = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    chk({nbusrq, oe, nmreq, nrd, nwr} == 5'b10111, "reset_bus_outputs",
        {nbusrq, oe, nmreq, nrd, nwr}, 5'b10111);
    chk({busy, done} == 2'b00, "reset_busy_done", {busy, done}, 0);
    chk({remain, addr, dout} == 40'd0, "reset_data_outputs", {remain, addr, dout}, 0);
    nclr = 1'b1;
    mon_en = 1'b1;

    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2; mem[16'h0012] = 8'hC3;
    run_xfer(16'h0010, 16'h0100, 16'd3, 0, 0, 1'b0);
    chk({mem[16'h0100], mem[16'h0101], mem[16'h0102]} == 24'hA1B2C3, "basic_copy_ram",
        {mem[16'h0100], mem[16'h0101], mem[16'h0102]}, 24'hA1B2C3);
    chk(wr_log.size() == 3, "basic_write_strobes", wr_log.size(), 3);

    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'h3C;
    run_xfer(16'hFFFF, 16'h0FFE, 16'd2, 0, 0, 1'b0);
    chk(rd_log.size() == 2, "wrap_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk(rd_log[0] == 16'hFFFF, "wrap_read0", rd_log[0], 16'hFFFF);
      chk(rd_log[1] == 16'h0000, "wrap_read1", rd_log[1], 16'h0000);
    end
    chk(wr_log.size() == 2, "wrap_writes", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk(wr_log[0] == 24'h0FFE5A, "wrap_write0", wr_log[0], 24'h0FFE5A);
      chk(wr_log[1] == 24'h0FFF3C, "wrap_write1", wr_log[1], 24'h0FFF3C);
    end

    gnt_d = 2;
    run_xfer(16'h4000, 16'h5000, 16'd10, 0, 0, 1'b0);
    chk(ten_log.size() == 3, "burst_tenures", ten_log.size(), 3);
    if (ten_log.size() == 3)
      chk({ten_log[0], ten_log[1], ten_log[2]} == {32'd4, 32'd4, 32'd2}, "burst_split_4_4_2",
          {8'(ten_log[0]), 8'(ten_log[1]), 8'(ten_log[2])}, 24'h040402);

    gnt_d = 1;
    run_xfer(16'h6000, 16'h7000, 16'd8, 2, 3, 1'b0);
    chk(last_rem == 16'd5, "abort_remain_5", last_rem, 5);
    chk(wr_log.size() == 3, "abort_three_bytes", wr_log.size(), 3);

    run_xfer(16'h6100, 16'h7100, 16'd5, 1, 0, 1'b0);
    chk(last_rem == 16'd5 && wr_log.size() == 0, "abort_in_req",
        {last_rem, 16'(wr_log.size())}, {16'd5, 16'd0});

    zero_len();
    run_xfer(16'h8000, 16'h9000, 16'd6, 0, 0, 1'b1);
    chk(last_rem == 16'd0 && wr_log.size() == 6, "busy_start_ignored",
        {last_rem, 16'(wr_log.size())}, {16'd0, 16'd6});

    reset_mid_write();

    for (int it = 0; it < 24; it++) begin
      gnt_d = $urandom_range(1, 4);
      glitch_en = 1'($urandom_range(0, 1));
      if (it % 6 == 5) begin
        zero_len();
      end else begin
        l = $urandom_range(1, 20);
        mode = $urandom_range(0, 2);
        k = $urandom_range(1, l);
        run_xfer(16'($urandom), 16'($urandom), 16'(l), mode, k,
                 $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
